uart_rx_ctrl: RTL

Frame-sequencing controller for the UART receiver: it tracks the serial line, counts oversampling edges and bit positions, and pulses the enables that drive the data sampler, deserializer, start check, parity check and stop check. It also collects the checker verdicts and issues a single `data_valid` per error-free frame. It sits between the RX pin synchronizer and the RX datapath blocks, in the UART RX clock domain.

---
 rtl/uart_rx_pkg.sv | 35 +++
 rtl/uart_rx_edge_bit_counter.sv | 38 +++
 rtl/uart_rx_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Holds the FSM state encoding, legal prescale values and the check-point offset.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;

  localparam int DATA_BITS = 8;
  localparam int BIT_W     = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  // Any prescale outside the supported set falls back to 8x oversampling.
  function automatic logic [5:0] legal_prescale(input logic [5:0] presc);
    case (presc)
      PRESC_16: return PRESC_16;
      PRESC_32: return PRESC_32;
      default:  return PRESC_8;
    endcase
  endfunction

  // First edge after the three-sample majority window around mid-bit closes.
  function automatic logic [5:0] check_point(input logic [5:0] p);
    return (p >> 1) + 6'd2;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and data-bit index for the UART receiver.
// Counts 0..P-1 while enabled, flags the last edge of each bit, holds zero when idle.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             bit_inc_i,
  input  logic [5:0]       prescale_i,
  output logic [5:0]       edge_cnt_o,
  output logic [BIT_W-1:0] bit_idx_o,
  output logic             wrap_o
);

  logic [5:0]       edge_cnt_q;
  logic [BIT_W-1:0] bit_idx_q;

  assign wrap_o     = en_i && (edge_cnt_q == prescale_i - 6'd1);
  assign edge_cnt_o = edge_cnt_q;
  assign bit_idx_o  = bit_idx_q;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || !en_i) begin
      edge_cnt_q <= '0;
      bit_idx_q  <= '0;
    end else if (wrap_o) begin
      edge_cnt_q <= '0;
      if (bit_inc_i) bit_idx_q <= bit_idx_q + BIT_W'(1);
    end else begin
      edge_cnt_q <= edge_cnt_q + 6'd1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Frame sequencer for the UART receiver: walks START/DATA/PARITY/STOP, pulses the
// datapath enables at the check point and reports one verdict per completed frame.
module uart_rx_ctrl
  import uart_rx_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic [5:0]       PRESCALE,
  input  logic             strt_glitch,
  input  logic             par_err,
  input  logic             stp_err,
  output logic [5:0]       edge_cnt,
  output logic [BIT_W-1:0] bit_idx,
  output logic             dat_samp_en,
  output logic             deser_en,
  output logic             strt_chk_en,
  output logic             par_chk_en,
  output logic             stp_chk_en,
  output logic             data_valid,
  output logic             PAR_ERR,
  output logic             STP_ERR
);

  rx_state_e  state_q;
  logic [5:0] p_q;
  logic       pe_q;
  logic       par_flag_q;
  logic       stp_flag_q;
  logic       data_valid_q;
  logic       par_err_q;
  logic       stp_err_q;

  logic       wrap;
  logic       at_cp;
  logic       glitch_abort;

  uart_rx_edge_bit_counter u_counter (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (dat_samp_en),
    .clr_i      (glitch_abort),
    .bit_inc_i  (state_q == ST_DATA),
    .prescale_i (p_q),
    .edge_cnt_o (edge_cnt),
    .bit_idx_o  (bit_idx),
    .wrap_o     (wrap)
  );

  // Enables decode only registered state and counter, never RX_IN.
  assign at_cp        = (edge_cnt == check_point(p_q));
  assign dat_samp_en  = (state_q != ST_IDLE);
  assign strt_chk_en  = (state_q == ST_START)  && at_cp;
  assign deser_en     = (state_q == ST_DATA)   && at_cp;
  assign par_chk_en   = (state_q == ST_PARITY) && at_cp;
  assign stp_chk_en   = (state_q == ST_STOP)   && at_cp;
  assign glitch_abort = strt_chk_en && strt_glitch;

  assign data_valid = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      p_q          <= PRESC_8;
      pe_q         <= 1'b0;
      par_flag_q   <= 1'b0;
      stp_flag_q   <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!RX_IN) begin
            state_q    <= ST_START;
            p_q        <= legal_prescale(PRESCALE);
            pe_q       <= PAR_EN;
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
          end
        end
        ST_START: begin
          if (glitch_abort) state_q <= ST_IDLE;
          else if (wrap)    state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (wrap && (bit_idx == LAST_BIT)) state_q <= pe_q ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (par_chk_en) par_flag_q <= par_err;
          if (wrap)       state_q    <= ST_STOP;
        end
        ST_STOP: begin
          if (stp_chk_en) stp_flag_q <= stp_err;
          if (wrap) begin
            state_q      <= ST_IDLE;
            par_err_q    <= pe_q && par_flag_q;
            stp_err_q    <= stp_flag_q;
            data_valid_q <= !(pe_q && par_flag_q) && !stp_flag_q;
          end
        end
        // NOTE: the default arm returns any unreachable encoding to IDLE so the
        // case is full and no state can hang.
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
